fetch_ctrl: RTL and testbench

Instruction-fetch sequencer in front of instruction memory. Owns the fetch PC and runs a single-outstanding-request handshake to imem. Applies trap and branch redirects, discarding stale responses, and presents fetched instructions to decode through a valid/stall interface. Replaces the bare PC register as the source of fetch addresses.

---
 rtl/fetch_ctrl_if.sv | 32 +++
 rtl/fetch_ctrl.sv | 100 ++++++++++
 tb/tb_fetch_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Fetch-side bundle: decode handshake, redirect inputs and the imem request/response bus.
// The master modport is the fetch sequencer; the slave modport is its environment.
interface fetch_ctrl_if #(
  parameter int unsigned PC_WIDTH = 32
);
  logic                stall_i;
  logic                br_taken_i;
  logic [PC_WIDTH-1:0] br_target_i;
  logic                trap_i;
  logic [PC_WIDTH-1:0] trap_target_i;
  logic                imem_req_o;
  logic [PC_WIDTH-1:0] imem_addr_o;
  logic                imem_gnt_i;
  logic                imem_rvalid_i;
  logic [31:0]         imem_rdata_i;
  logic                if_valid_o;
  logic [PC_WIDTH-1:0] if_pc_o;
  logic [31:0]         if_instr_o;
  logic [PC_WIDTH-1:0] pc_o;

  modport master (
    input  stall_i, br_taken_i, br_target_i, trap_i, trap_target_i,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    output imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_instr_o, pc_o
  );

  modport slave (
    output stall_i, br_taken_i, br_target_i, trap_i, trap_target_i,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    input  imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_instr_o, pc_o
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, keeps one imem request in flight,
// applies trap/branch redirects and drops responses that a redirect made stale.
module fetch_ctrl #(
  parameter int unsigned         PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst,
  fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {StRst, StReq, StWait, StDrop} state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] req_pc_q, req_pc_d;
  logic [PC_WIDTH-1:0] if_pc_q, if_pc_d;
  logic [31:0]         if_instr_q, if_instr_d;
  logic                if_valid_q, if_valid_d;
  logic                req;
  logic                redirect;
  logic [PC_WIDTH-1:0] target;

  // Trap wins over branch; redirect targets are always word aligned.
  always_comb begin
    redirect    = bus.trap_i || bus.br_taken_i;
    target      = bus.trap_i ? bus.trap_target_i : bus.br_target_i;
    target[1:0] = 2'b00;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q && bus.stall_i;
    req        = 1'b0;

    unique case (state_q)
      StRst: state_d = StReq;
      StReq: begin
        // Only request when the output slot is empty or being consumed this cycle.
        req = !if_valid_q || !bus.stall_i;
        if (req && bus.imem_gnt_i) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + PC_WIDTH'(4);
          state_d  = redirect ? StDrop : StWait;
        end
      end
      StWait: begin
        if (bus.imem_rvalid_i) begin
          state_d = StReq;
          if (!redirect) begin
            if_pc_d    = req_pc_q;
            if_instr_d = bus.imem_rdata_i;
            if_valid_d = 1'b1;
          end
        end else if (redirect) begin
          state_d = StDrop;
        end
      end
      StDrop: begin
        if (bus.imem_rvalid_i) state_d = StReq;
      end
      default: state_d = StRst;
    endcase

    if (redirect) begin
      pc_d       = target;
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRst;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign bus.imem_req_o  = req;
  assign bus.imem_addr_o = pc_q;
  assign bus.pc_o        = pc_q;
  assign bus.if_valid_o  = if_valid_q;
  assign bus.if_pc_o     = if_pc_q;
  assign bus.if_instr_o  = if_instr_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus a randomized run against a
// transaction-level model (one outstanding fetch, tagged live or stale, and an output slot).
module tb_fetch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  fetch_ctrl_if #(.PC_WIDTH(32)) bus ();

  fetch_ctrl #(.PC_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state.
  bit          m_started;
  logic [31:0] m_pc;
  bit          m_pend;
  bit          m_live;
  logic [31:0] m_ppc;
  bit          m_sv;
  logic [31:0] m_spc;
  logic [31:0] m_sins;

  function automatic bit m_req();
    return m_started && !m_pend && (!m_sv || !bus.stall_i);
  endfunction

  // Advance the model by one clock using the current inputs, then move to the next negedge.
  task automatic cyc();
    bit          redir;
    logic [31:0] tgt;
    bit          ereq;
    redir = bus.trap_i || bus.br_taken_i;
    tgt   = (bus.trap_i ? bus.trap_target_i : bus.br_target_i) & ~32'd3;
    ereq  = m_req();
    if (!m_started) begin
      m_started = 1;
    end else begin
      if (m_sv && !bus.stall_i) m_sv = 0;
      if (ereq && bus.imem_gnt_i) begin
        m_pend = 1;
        m_live = !redir;
        m_ppc  = m_pc;
        m_pc   = m_pc + 32'd4;
      end else if (m_pend && bus.imem_rvalid_i) begin
        m_pend = 0;
        if (m_live && !redir) begin
          m_sv   = 1;
          m_spc  = m_ppc;
          m_sins = bus.imem_rdata_i;
        end
      end else if (m_pend && redir) begin
        m_live = 0;
      end
    end
    if (redir) begin
      m_pc = tgt;
      m_sv = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.stall_i       = 0;
    bus.br_taken_i    = 0;
    bus.br_target_i   = '0;
    bus.trap_i        = 0;
    bus.trap_target_i = '0;
    bus.imem_gnt_i    = 0;
    bus.imem_rvalid_i = 0;
    bus.imem_rdata_i  = '0;
  endtask

  task automatic model_reset();
    m_started = 0; m_pc = 32'h0; m_pend = 0; m_live = 0;
    m_ppc = '0; m_sv = 0; m_spc = '0; m_sins = '0;
  endtask

  // Leaves the DUT just after the RST->REQ edge, at a negedge.
  task automatic do_reset();
    clear_inputs();
    rst = 1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    cyc();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    model_reset();
    @(negedge clk);
    #1;
    checks++; if (bus.pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", bus.pc_o); end
    checks++; if (bus.if_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.if_valid_o); end
    checks++; if (bus.if_pc_o !== 32'h0) begin errors++; $display("FAIL reset_if_pc got=%h exp=0", bus.if_pc_o); end
    checks++; if (bus.if_instr_o !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", bus.if_instr_o); end
    checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", bus.imem_req_o); end
  endtask

  task automatic test_stream();
    do_reset();
    bus.imem_gnt_i = 1; bus.imem_rvalid_i = 1; bus.imem_rdata_i = 32'h13;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (bus.imem_req_o !== 1'b1) begin errors++; $display("FAIL stream_req k=%0d got=%b exp=1", k, bus.imem_req_o); end
      checks++; if (bus.imem_addr_o !== 32'(4 * k)) begin errors++; $display("FAIL stream_addr got=%h exp=%h", bus.imem_addr_o, 4 * k); end
      cyc();
      #1;
      checks++; if (bus.if_valid_o !== 1'b0) begin errors++; $display("FAIL stream_gap got=%b exp=0", bus.if_valid_o); end
      cyc();
      #1;
      checks++; if (bus.if_valid_o !== 1'b1) begin errors++; $display("FAIL stream_valid k=%0d got=%b exp=1", k, bus.if_valid_o); end
      checks++; if (bus.if_pc_o !== 32'(4 * k)) begin errors++; $display("FAIL stream_if_pc got=%h exp=%h", bus.if_pc_o, 4 * k); end
    end
  endtask

  task automatic test_stall_hold();
    do_reset();
    bus.imem_gnt_i = 1; bus.imem_rvalid_i = 1; bus.imem_rdata_i = 32'h0000_0013;
    cyc();
    bus.stall_i = 1;
    cyc();
    for (int k = 0; k < 3; k++) begin
      bus.imem_rdata_i = $urandom;
      #1;
      checks++; if (bus.if_valid_o !== 1'b1) begin errors++; $display("FAIL hold_valid got=%b exp=1", bus.if_valid_o); end
      checks++; if (bus.if_pc_o !== 32'h0) begin errors++; $display("FAIL hold_pc got=%h exp=0", bus.if_pc_o); end
      checks++; if (bus.if_instr_o !== 32'h13) begin errors++; $display("FAIL hold_instr got=%h exp=13", bus.if_instr_o); end
      checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL hold_req got=%b exp=0", bus.imem_req_o); end
      cyc();
    end
    bus.stall_i = 0;
    #1;
    checks++; if (bus.imem_req_o !== 1'b1) begin errors++; $display("FAIL resume_req got=%b exp=1", bus.imem_req_o); end
    checks++; if (bus.imem_addr_o !== 32'h4) begin errors++; $display("FAIL resume_addr got=%h exp=4", bus.imem_addr_o); end
    cyc();
    cyc();
    #1;
    checks++; if (bus.if_pc_o !== 32'h4 || bus.if_valid_o !== 1'b1) begin
      errors++; $display("FAIL resume_if got=%b/%h exp=1/4", bus.if_valid_o, bus.if_pc_o);
    end
  endtask

  task automatic test_branch_wait();
    do_reset();
    bus.imem_gnt_i = 1;
    cyc();
    bus.br_taken_i = 1; bus.br_target_i = 32'h103;
    cyc();
    bus.br_taken_i = 0;
    #1;
    checks++; if (bus.pc_o !== 32'h100) begin errors++; $display("FAIL br_pc got=%h exp=100", bus.pc_o); end
    checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL br_drop_req got=%b exp=0", bus.imem_req_o); end
    bus.imem_rvalid_i = 1; bus.imem_rdata_i = 32'hDEAD_BEEF;
    cyc();
    #1;
    checks++; if (bus.if_valid_o !== 1'b0) begin errors++; $display("FAIL br_stale got=%b exp=0", bus.if_valid_o); end
    checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h100) begin
      errors++; $display("FAIL br_req got=%b/%h exp=1/100", bus.imem_req_o, bus.imem_addr_o);
    end
    bus.imem_rdata_i = 32'h13;
    cyc();
    cyc();
    #1;
    checks++; if (bus.if_valid_o !== 1'b1 || bus.if_pc_o !== 32'h100) begin
      errors++; $display("FAIL br_first got=%b/%h exp=1/100", bus.if_valid_o, bus.if_pc_o);
    end
  endtask

  task automatic test_trap_priority();
    do_reset();
    bus.imem_gnt_i = 1; bus.imem_rvalid_i = 1; bus.imem_rdata_i = 32'h13; bus.stall_i = 1;
    cyc();
    cyc();
    #1;
    checks++; if (bus.if_valid_o !== 1'b1) begin errors++; $display("FAIL trap_held got=%b exp=1", bus.if_valid_o); end
    bus.trap_i = 1; bus.trap_target_i = 32'h80;
    bus.br_taken_i = 1; bus.br_target_i = 32'h200;
    cyc();
    bus.trap_i = 0; bus.br_taken_i = 0;
    #1;
    checks++; if (bus.pc_o !== 32'h80) begin errors++; $display("FAIL trap_pc got=%h exp=80", bus.pc_o); end
    checks++; if (bus.if_valid_o !== 1'b0) begin errors++; $display("FAIL trap_flush got=%b exp=0", bus.if_valid_o); end
    checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h80) begin
      errors++; $display("FAIL trap_req got=%b/%h exp=1/80", bus.imem_req_o, bus.imem_addr_o);
    end
  endtask

  task automatic test_redirect_gnt();
    do_reset();
    bus.imem_gnt_i = 1; bus.br_taken_i = 1; bus.br_target_i = 32'h40;
    cyc();
    bus.br_taken_i = 0;
    #1;
    checks++; if (bus.pc_o !== 32'h40) begin errors++; $display("FAIL rg_pc got=%h exp=40", bus.pc_o); end
    checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL rg_drop_req got=%b exp=0", bus.imem_req_o); end
    bus.imem_rvalid_i = 1; bus.imem_rdata_i = 32'h0BAD_0BAD;
    cyc();
    #1;
    checks++; if (bus.if_valid_o !== 1'b0) begin errors++; $display("FAIL rg_stale got=%b exp=0", bus.if_valid_o); end
    checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h40) begin
      errors++; $display("FAIL rg_req got=%b/%h exp=1/40", bus.imem_req_o, bus.imem_addr_o);
    end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    bus.trap_i = 1; bus.trap_target_i = 32'hFFFF_FFFC;
    cyc();
    bus.trap_i = 0;
    #1;
    checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_req got=%b/%h exp=1/fffffffc", bus.imem_req_o, bus.imem_addr_o);
    end
    bus.imem_gnt_i = 1;
    cyc();
    bus.imem_gnt_i = 0;
    #1;
    checks++; if (bus.pc_o !== 32'h0) begin errors++; $display("FAIL wrap_pc got=%h exp=0", bus.pc_o); end
    bus.trap_i = 1; bus.trap_target_i = 32'h500;
    cyc();
    bus.trap_i = 0;
    #1;
    // Now in flight to a dropped response with pc at 0x500; reset asynchronously.
    rst = 1;
    model_reset();
    #1;
    checks++; if (bus.pc_o !== 32'h0) begin errors++; $display("FAIL rst_mid_pc got=%h exp=0", bus.pc_o); end
    checks++; if (bus.if_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", bus.if_valid_o); end
    @(negedge clk);
    rst = 0;
    bus.imem_rvalid_i = 1; bus.imem_rdata_i = 32'h1234_5678;
    cyc();
    bus.imem_rvalid_i = 0;
    #1;
    checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin
      errors++; $display("FAIL rst_restart got=%b/%h exp=1/0", bus.imem_req_o, bus.imem_addr_o);
    end
    checks++; if (bus.if_valid_o !== 1'b0) begin errors++; $display("FAIL rst_ignore got=%b exp=0", bus.if_valid_o); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bus.stall_i       = ($urandom_range(0, 9) < 3);
      bus.br_taken_i    = ($urandom_range(0, 99) < 8);
      bus.br_target_i   = $urandom;
      bus.trap_i        = ($urandom_range(0, 99) < 4);
      bus.trap_target_i = $urandom;
      bus.imem_gnt_i    = ($urandom_range(0, 9) < 6);
      bus.imem_rvalid_i = ($urandom_range(0, 9) < 6);
      bus.imem_rdata_i  = $urandom;
      #1;
      checks++; if (bus.imem_req_o !== m_req()) begin
        errors++; $display("FAIL rnd_req n=%0d got=%b exp=%b", n, bus.imem_req_o, m_req());
      end
      checks++; if (bus.imem_addr_o !== m_pc || bus.pc_o !== m_pc) begin
        errors++; $display("FAIL rnd_pc n=%0d got=%h/%h exp=%h", n, bus.imem_addr_o, bus.pc_o, m_pc);
      end
      checks++; if (bus.if_valid_o !== m_sv) begin
        errors++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, bus.if_valid_o, m_sv);
      end
      if (m_sv) begin
        checks++; if (bus.if_pc_o !== m_spc || bus.if_instr_o !== m_sins) begin
          errors++; $display("FAIL rnd_if n=%0d got=%h/%h exp=%h/%h", n, bus.if_pc_o, bus.if_instr_o,
                             m_spc, m_sins);
        end
      end
      cyc();
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_stream();
    test_stall_hold();
    test_branch_wait();
    test_trap_priority();
    test_redirect_gnt();
    test_wrap_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
